// File: rtl/decode_sequencer_if.sv
// Fetch-side, immediate-generator and downstream bundle signals of decode_sequencer.
// The slave modport is the sequencer itself; master is its environment.
interface decode_sequencer_if;
    localparam int XLEN = 32;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [2:0]      imm_fmt;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] imm_in;
    logic            dec_valid;
    logic            dec_ready;
    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [2:0]      dec_funct3;
    logic [6:0]      dec_funct7;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic [31:0]     dec_count;

    modport slave (
        input  instr_valid, instr_data, imm_in, dec_ready,
        output instr_ready, imm_fmt, ir, dec_valid, dec_opcode, dec_rd, dec_rs1,
               dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal, dec_count
    );

    modport master (
        output instr_valid, instr_data, imm_in, dec_ready,
        input  instr_ready, imm_fmt, ir, dec_valid, dec_opcode, dec_rd, dec_rs1,
               dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal, dec_count
    );
endinterface

// File: rtl/decode_sequencer.sv
// Three-state IDLE/DECODE/VALID front end: captures an instruction, steers the
// shared immediate generator, and holds one decoded bundle for the execute side.
module decode_sequencer (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    decode_sequencer_if.slave bus
);
    localparam int XLEN = 32;

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        VALID  = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] fmt;
        logic       illegal;
    } fmt_sel_t;

    function automatic fmt_sel_t select_fmt(input logic [6:0] opcode);
        fmt_sel_t sel;
        sel = '{fmt: FMT_NONE, illegal: 1'b0};
        case (opcode)
            7'b0110111, 7'b0010111: sel.fmt = FMT_U;
            7'b1101111:             sel.fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: sel.fmt = FMT_I;
            7'b0100011:             sel.fmt = FMT_S;
            7'b1100011:             sel.fmt = FMT_B;
            7'b0110011:             sel.fmt = FMT_NONE;
            default:                sel.illegal = 1'b1;
        endcase
        return sel;
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] dec_imm_q, dec_imm_d;
    logic            dec_illegal_q, dec_illegal_d;
    logic [31:0]     dec_count_q, dec_count_d;
    fmt_sel_t        dec_sel;

    assign dec_sel = select_fmt(ir_q[6:0]);

    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        dec_imm_d     = dec_imm_q;
        dec_illegal_d = dec_illegal_q;
        dec_count_d   = dec_count_q;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                dec_imm_d     = (dec_sel.fmt == FMT_NONE) ? '0 : bus.imm_in;
                dec_illegal_d = dec_sel.illegal;
                state_d       = VALID;
            end
            VALID: begin
                if (bus.dec_ready) begin
                    dec_count_d = dec_count_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every transition; bundle registers keep their old contents.
        if (flush) begin
            state_d       = IDLE;
            ir_d          = ir_q;
            dec_imm_d     = dec_imm_q;
            dec_illegal_d = dec_illegal_q;
            dec_count_d   = dec_count_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ir_q          <= '0;
            dec_imm_q     <= '0;
            dec_illegal_q <= 1'b0;
            dec_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            dec_imm_q     <= dec_imm_d;
            dec_illegal_q <= dec_illegal_d;
            dec_count_q   <= dec_count_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE) && !reset;
    assign bus.imm_fmt     = (state_q == DECODE) ? dec_sel.fmt : FMT_NONE;
    assign bus.ir          = ir_q;
    assign bus.dec_valid   = (state_q == VALID);
    assign bus.dec_opcode  = ir_q[6:0];
    assign bus.dec_rd      = ir_q[11:7];
    assign bus.dec_funct3  = ir_q[14:12];
    assign bus.dec_rs1     = ir_q[19:15];
    assign bus.dec_rs2     = ir_q[24:20];
    assign bus.dec_funct7  = ir_q[31:25];
    assign bus.dec_imm     = dec_imm_q;
    assign bus.dec_illegal = dec_illegal_q;
    assign bus.dec_count   = dec_count_q;
endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer with a behavioural immediate generator and
// an expected-bundle scoreboard filled on capture and drained when dec_valid rises.
module tb_decode_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    decode_sequencer_if intf ();

    decode_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;

    // Shared immediate generator: combinational from ir and imm_fmt.
    always_comb begin
        logic [31:0] g;
        g = intf.ir;
        case (intf.imm_fmt)
            3'd0:    intf.imm_in = {{20{g[31]}}, g[31:20]};
            3'd1:    intf.imm_in = {{20{g[31]}}, g[31:25], g[11:7]};
            3'd2:    intf.imm_in = {{19{g[31]}}, g[31], g[7], g[30:25], g[11:8], 1'b0};
            3'd3:    intf.imm_in = {g[31:12], 12'h000};
            3'd4:    intf.imm_in = {{11{g[31]}}, g[31], g[19:12], g[20], g[30:21], 1'b0};
            default: intf.imm_in = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [31:0] word;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_count = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] word, input logic [2:0] fmt,
                         input logic [31:0] imm, input logic illegal);
        exp_t e;
        for (int i = 0; i < 20 && intf.instr_ready !== 1'b1; i++) step();
        check("offer_ready", {31'd0, intf.instr_ready}, 32'd1);
        intf.instr_valid = 1'b1;
        intf.instr_data  = word;
        step();
        intf.instr_valid = 1'b0;
        intf.instr_data  = $urandom;
        check("decode_fmt", {29'd0, intf.imm_fmt}, {29'd0, fmt});
        check("decode_busy", {31'd0, intf.instr_ready}, 32'd0);
        e.word = word;
        e.imm = imm;
        e.illegal = illegal;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        int   waited;
        waited = 0;
        step();
        while (intf.dec_valid !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        check("valid_rise", {31'd0, intf.dec_valid}, 32'd1);
        check("valid_latency", waited, 0);
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ir", intf.ir, e.word);
            check("imm", intf.dec_imm, e.imm);
            check("illegal", {31'd0, intf.dec_illegal}, {31'd0, e.illegal});
            check("opcode", {25'd0, intf.dec_opcode}, {25'd0, e.word[6:0]});
            check("rd", {27'd0, intf.dec_rd}, {27'd0, e.word[11:7]});
            check("rs1", {27'd0, intf.dec_rs1}, {27'd0, e.word[19:15]});
            check("rs2", {27'd0, intf.dec_rs2}, {27'd0, e.word[24:20]});
            check("funct3", {29'd0, intf.dec_funct3}, {29'd0, e.word[14:12]});
            check("funct7", {25'd0, intf.dec_funct7}, {25'd0, e.word[31:25]});
            check("fmt_idle", {29'd0, intf.imm_fmt}, 32'd7);
        end
    endtask

    task automatic handshake();
        intf.dec_ready = 1'b1;
        step();
        intf.dec_ready = 1'b0;
        exp_count++;
        check("hs_valid_drop", {31'd0, intf.dec_valid}, 32'd0);
        check("hs_idle", {31'd0, intf.instr_ready}, 32'd1);
        check("hs_count", intf.dec_count, exp_count);
    endtask

    initial begin
        intf.instr_valid = 1'b0;
        intf.instr_data  = '0;
        intf.dec_ready   = 1'b0;

        // Two reset cycles, then reset values.
        step();
        step();
        check("rst_ready", {31'd0, intf.instr_ready}, 32'd0);
        check("rst_fmt", {29'd0, intf.imm_fmt}, 32'd7);
        check("rst_valid", {31'd0, intf.dec_valid}, 32'd0);
        check("rst_ir", intf.ir, 32'd0);
        check("rst_imm", intf.dec_imm, 32'd0);
        check("rst_illegal", {31'd0, intf.dec_illegal}, 32'd0);
        check("rst_count", intf.dec_count, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", {31'd0, intf.instr_ready}, 32'd1);

        // I-format: ADDI x1,x0,-1.
        offer(32'hFFF0_0093, 3'd0, 32'hFFFF_FFFF, 1'b0);
        collect();
        handshake();

        // U-format, then backpressure with a B-format word pending.
        offer(32'h1234_5537, 3'd3, 32'h1234_5000, 1'b0);
        collect();
        intf.instr_valid = 1'b1;
        intf.instr_data  = 32'hFE00_0EE3;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", {31'd0, intf.dec_valid}, 32'd1);
            check("bp_ready", {31'd0, intf.instr_ready}, 32'd0);
            check("bp_imm", intf.dec_imm, 32'h1234_5000);
            check("bp_ir", intf.ir, 32'h1234_5537);
        end
        handshake();
        step();
        intf.instr_valid = 1'b0;
        check("bp_pending_fmt", {29'd0, intf.imm_fmt}, 32'd2);
        check("bp_pending_busy", {31'd0, intf.instr_ready}, 32'd0);
        sb.push_back('{word: 32'hFE00_0EE3, imm: 32'hFFFF_FFFC, illegal: 1'b0});
        collect();
        handshake();

        // Illegal opcode and OP (no immediate; generator output is garbage).
        offer(32'h0000_007F, 3'd7, 32'h0000_0000, 1'b1);
        collect();
        handshake();
        offer(32'h0020_81B3, 3'd7, 32'h0000_0000, 1'b0);
        collect();
        handshake();

        // Flush in DECODE: nothing reaches VALID, count unchanged.
        offer(32'hFE11_2E23, 3'd1, 32'hFFFF_FFFC, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        void'(sb.pop_back());
        check("flush_dec_ready", {31'd0, intf.instr_ready}, 32'd1);
        check("flush_dec_valid", {31'd0, intf.dec_valid}, 32'd0);
        check("flush_dec_count", intf.dec_count, exp_count);
        step();
        check("flush_dec_stays_idle", {31'd0, intf.dec_valid}, 32'd0);

        // Flush in VALID with dec_ready high: no count increment.
        offer(32'h0080_006F, 3'd4, 32'h0000_0008, 1'b0);
        collect();
        flush = 1'b1;
        intf.dec_ready = 1'b1;
        step();
        flush = 1'b0;
        intf.dec_ready = 1'b0;
        check("flush_val_valid", {31'd0, intf.dec_valid}, 32'd0);
        check("flush_val_ready", {31'd0, intf.instr_ready}, 32'd1);
        check("flush_val_count", intf.dec_count, exp_count);

        // Flush together with an offer in IDLE: not captured.
        intf.instr_valid = 1'b1;
        intf.instr_data  = 32'h1234_5537;
        flush = 1'b1;
        step();
        flush = 1'b0;
        intf.instr_valid = 1'b0;
        check("flush_idle_fmt", {29'd0, intf.imm_fmt}, 32'd7);
        check("flush_idle_ready", {31'd0, intf.instr_ready}, 32'd1);

        // Reset mid-VALID.
        offer(32'hFFF0_0093, 3'd0, 32'hFFFF_FFFF, 1'b0);
        collect();
        reset = 1'b1;
        step();
        check("rst2_valid", {31'd0, intf.dec_valid}, 32'd0);
        check("rst2_ready", {31'd0, intf.instr_ready}, 32'd0);
        check("rst2_ir", intf.ir, 32'd0);
        check("rst2_imm", intf.dec_imm, 32'd0);
        check("rst2_count", intf.dec_count, 32'd0);
        check("rst2_fmt", {29'd0, intf.imm_fmt}, 32'd7);
        reset = 1'b0;
        exp_count = '0;
        #1;
        check("rst2_release_ready", {31'd0, intf.instr_ready}, 32'd1);

        // Counter wrap.
        force dut.dec_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.dec_count_q;
        exp_count = 32'hFFFF_FFFF;
        check("wrap_preload", intf.dec_count, exp_count);
        offer(32'h0020_81B3, 3'd7, 32'h0000_0000, 1'b0);
        collect();
        handshake();
        check("wrap_zero", intf.dec_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

Multicycle front-end controller that accepts a fetched instruction, captures it in an instruction register, and selects the immediate format for the shared immediate generator. It then registers the generated immediate with the decoded register and function fields and presents one decoded bundle downstream over a valid/ready handshake. It sits between instruction fetch and the execute sequencer, and is the only block that drives the immediate generator's format select.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- FMT_I/S/B/U/J, 0/1/2/3/4, immediate format codes understood by the immediate generator.
- FMT_NONE, 7, format code driven when no immediate applies; the generator output is ignored for this code.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous abort: drop any held instruction and return to IDLE.
- instr_valid  in  1  fetch offers instr_data.
- instr_ready  out  1  high only in IDLE while reset is low.
- instr_data  in  XLEN  raw instruction word.
- imm_fmt  out  3  format select to the immediate generator.
- ir  out  XLEN  instruction register; feeds the generator's instruction input.
- imm_in  in  XLEN  immediate returned by the generator (combinational from ir and imm_fmt).
- dec_valid  out  1  decoded bundle valid.
- dec_ready  in  1  downstream accepts the bundle.
- dec_opcode  out  7  ir[6:0].
- dec_rd, dec_rs1, dec_rs2  out  5 each  ir[11:7], ir[19:15], ir[24:20].
- dec_funct3  out  3  ir[14:12].
- dec_funct7  out  7  ir[31:25].
- dec_imm  out  XLEN  registered immediate.
- dec_illegal  out  1  the opcode is not an RV32I opcode.
- dec_count  out  32  count of completed dec handshakes; wraps modulo 2^32.

## Operation
- The state machine has three states: IDLE, DECODE and VALID.
- **IDLE:** instr_ready=1. On instr_valid at the clock edge, ir <= instr_data and the state moves to DECODE.
- **DECODE:** imm_fmt is driven from ir[6:0]. At the edge, dec_imm <= imm_in, the state moves to VALID, and dec_illegal is registered.
- **VALID:** dec_valid=1. When dec_ready is high, the state moves to IDLE and dec_count increments.
- **Opcode to format map:**
  - 0110111 LUI and 0010111 AUIPC select U.
  - 1101111 JAL selects J.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM and 1110011 SYSTEM select I.
  - 0100011 STORE selects S.
  - 1100011 BRANCH selects B.
  - 0110011 OP selects FMT_NONE.
  - Any other opcode selects FMT_NONE and sets dec_illegal=1.
- **FMT_NONE:** dec_imm is forced to 0. The generator output is ignored.
- **imm_fmt outside DECODE:** FMT_NONE.
- **Bundle stability:** dec_* fields and dec_imm are stable for as long as dec_valid is high.
- **Field sourcing:** dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7 and dec_opcode are wired directly from ir.
- **flush:** Takes priority over every transition. The next state is IDLE, dec_valid drops on the next cycle, and dec_count does not increment even if dec_ready is high in the same cycle. An instruction offered in IDLE together with flush is not captured.
- **Reset:** Has priority over flush. After a reset edge, the block is in the state given in the reset-values item under Timing.

## Timing
- **Reset values:**
  - The state machine is in IDLE.
  - ir, dec_imm and dec_count are 0.
  - dec_illegal and dec_valid are 0.
  - imm_fmt is 7 (FMT_NONE).
  - instr_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
- **Capture to bundle latency:** If the instruction is accepted at edge N, dec_valid is high in the cycle following edge N+1.
- **Throughput:** At best one instruction every 3 cycles. instr_ready is low in DECODE and VALID.
- **Backpressure:** While dec_ready is low, VALID holds indefinitely with all outputs unchanged.
- **dec_count:** Updates at the same edge as the handshake that completes the bundle.
- **Generator path:** imm_in must settle within the cycle, combinationally from ir and imm_fmt. No cycle is added for it.
- **instr_data:** Sampled only at the accepting edge. Later changes have no effect.

## Test plan
- **I-format:** Reset 2 cycles, then offer 0xFFF00093 (ADDI x1,x0,-1). Required:
  - imm_fmt=0 in DECODE.
  - Two cycles after acceptance: dec_valid=1, dec_imm=0xFFFFFFFF, dec_rd=1, dec_illegal=0.
  - dec_count=1 after dec_ready.
- **U and B formats:** Offer 0x12345537 (LUI x10). Required: imm_fmt=3, dec_imm=0x12345000. Then offer 0xFE000EE3 (BEQ x0,x0,-4). Required: imm_fmt=2, dec_imm=0xFFFFFFFC.
- **Backpressure:** Hold dec_ready=0 for 10 cycles in VALID. Required:
  - Bundle unchanged and instr_ready=0 throughout.
  - A pending instr_valid is not captured.
  - Release dec_ready: IDLE on the next cycle, and the pending word is accepted the cycle after.
- **Illegal and OP:** Offer 0x0000007F. Required: dec_illegal=1, dec_imm=0. Offer 0x002081B3 (ADD x3,x1,x2). Required: imm_fmt=7, dec_imm=0, dec_rs2=2.
- **Flush and count:** Assert flush in DECODE, then separately assert flush in VALID with dec_ready=1. Required: IDLE on the next cycle both times, dec_valid=0, dec_count unchanged.
- **Reset and wrap:** Assert reset mid-VALID. Required: all reset values next cycle. Preload dec_count to 0xFFFFFFFF via a run of handshakes, or force it in simulation, then complete one handshake. Required: dec_count=0.
